// File: rtl/cpu_debug_pkg.sv
// Shared constants and instruction encodings for the CPU JTAG debug command path.
package cpu_debug_pkg;

  localparam int unsigned SR_W_DEF    = 38;
  localparam int unsigned IR_W_DEF    = 2;
  localparam int unsigned ACT_BIT_DEF = 37;

  typedef enum logic [1:0] {
    IR_OCIMEM_A  = 2'd0,
    IR_OCIMEM_B  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_cmd_e;

endpackage

// File: rtl/cpu_debug_toggle_sync.sv
// Brings a TCK-domain toggle into clk and emits a one-cycle pulse per inversion.
module cpu_debug_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tog_in,
  output logic event_out
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], tog_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign event_out = chain[SYNC_STAGES-1] ^ prev;

endmodule

// File: rtl/cpu_debug_cmd_queue.sv
// Sysclk-side receiver: queues {ir, sr} on each update-DR and pops entries into
// registered per-instruction action strobes; update-IR flushes the queue.
module cpu_debug_cmd_queue
  import cpu_debug_pkg::*;
#(
  parameter int unsigned SR_W        = SR_W_DEF,
  parameter int unsigned IR_W        = IR_W_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACT_BIT     = ACT_BIT_DEF,
  localparam int unsigned N_CMD      = 2**IR_W,
  localparam int unsigned LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             udr_toggle,
  input  logic             uir_toggle,
  input  logic [SR_W-1:0]  sr,
  input  logic [IR_W-1:0]  ir_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [SR_W-1:0]  jdo,
  output logic [IR_W-1:0]  jir,
  output logic [N_CMD-1:0] take_action,
  output logic [N_CMD-1:0] take_no_action
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic             udr_evt;
  logic             uir_evt;
  logic             pop;
  logic             push_ok;
  logic             full;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nx, rd_ptr_nx, wr_idx;
  logic [LVL_W-1:0] level_nx;
  logic             overflow_nx;

  logic [SR_W-1:0]  mem_sr [DEPTH];
  logic [IR_W-1:0]  mem_ir [DEPTH];
  logic [SR_W-1:0]  head_sr;
  logic [IR_W-1:0]  head_ir;
  logic [N_CMD-1:0] head_onehot;

  cpu_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .tog_in    (udr_toggle),
    .event_out (udr_evt)
  );

  cpu_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .tog_in    (uir_toggle),
    .event_out (uir_evt)
  );

  assign cmd_valid   = (level != '0);
  assign full        = (level == FULL_LVL);
  assign head_sr     = mem_sr[rd_ptr];
  assign head_ir     = mem_ir[rd_ptr];
  assign head_onehot = N_CMD'(1) << head_ir;

  // A flush discards the head too, so no pop is taken on the flush edge;
  // a coinciding push then lands in the freshly emptied slot 0.
  assign pop = cmd_valid && cmd_ready && !uir_evt;

  always_comb begin
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    level_nx    = level;
    overflow_nx = overflow;
    wr_idx      = wr_ptr;
    push_ok     = 1'b0;
    if (uir_evt) begin
      wr_ptr_nx   = '0;
      rd_ptr_nx   = '0;
      level_nx    = '0;
      overflow_nx = 1'b0;
      wr_idx      = '0;
    end
    if (pop) begin
      rd_ptr_nx = rd_ptr + PTR_W'(1);
      level_nx  = level - LVL_W'(1);
    end
    if (udr_evt) begin
      if (uir_evt || !full || pop) begin
        push_ok   = 1'b1;
        wr_ptr_nx = wr_idx + PTR_W'(1);
        level_nx  = level_nx + LVL_W'(1);
      end else begin
        overflow_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      level    <= level_nx;
      overflow <= overflow_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_sr[wr_idx] <= sr;
      mem_ir[wr_idx] <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      jir            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else if (pop) begin
      jdo            <= head_sr;
      jir            <= head_ir;
      take_action    <= head_sr[ACT_BIT] ? head_onehot : '0;
      take_no_action <= head_sr[ACT_BIT] ? '0 : head_onehot;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_queue.sv
// Directed bench for cpu_debug_cmd_queue with hand-computed expectations.
module tb_cpu_debug_cmd_queue;

  localparam int unsigned SR_W  = 38;
  localparam int unsigned IR_W  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             udr_toggle = 1'b0;
  logic             uir_toggle = 1'b0;
  logic [SR_W-1:0]  sr = '0;
  logic [IR_W-1:0]  ir_in = '0;
  logic             cmd_ready = 1'b0;
  logic             cmd_valid;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [SR_W-1:0]  jdo;
  logic [IR_W-1:0]  jir;
  logic [3:0]       take_action;
  logic [3:0]       take_no_action;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_debug_cmd_queue #(
    .SR_W        (SR_W),
    .IR_W        (IR_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2),
    .ACT_BIT     (37)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .udr_toggle     (udr_toggle),
    .uir_toggle     (uir_toggle),
    .sr             (sr),
    .ir_in          (ir_in),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .level          (level),
    .overflow       (overflow),
    .jdo            (jdo),
    .jir            (jir),
    .take_action    (take_action),
    .take_no_action (take_no_action)
  );

  function automatic logic [SR_W-1:0] mk(input logic act, input logic [35:0] low);
    return {act, 1'b0, low};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset_n = 1'b0; udr_toggle = 1'b0; uir_toggle = 1'b0;
    cmd_ready = 1'b0; sr = '0; ir_in = '0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  // Holds ir/sr stable for SYNC_STAGES+2 edges after the toggle.
  task automatic push_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    ir_in = ir; sr = d; udr_toggle = ~udr_toggle;
    step(4);
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({cmd_valid, level, overflow} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {cmd_valid, level, overflow});
    end
    total++;
    if ({jdo, jir, take_action, take_no_action} !== '0) begin
      bad++; $display("FAIL reset_data got jdo=%h jir=%h ta=%b tna=%b exp all 0", jdo, jir, take_action, take_no_action);
    end
  endtask

  task automatic test_single;
    logic [SR_W-1:0] d;
    do_reset;
    d = mk(1'b1, 36'h123456789);
    ir_in = 2'd2; sr = d; udr_toggle = 1'b1;
    step(1);
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL lat_e0 got=%b exp=0", cmd_valid); end
    step(1);
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL lat_e1 got=%b exp=0", cmd_valid); end
    step(1);
    total++;
    if (cmd_valid !== 1'b1 || level !== 3'd1) begin
      bad++; $display("FAIL lat_e2 got valid=%b level=%0d exp valid=1 level=1", cmd_valid, level);
    end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    total++;
    if (take_action !== 4'b0100 || take_no_action !== 4'b0000) begin
      bad++; $display("FAIL single_strobe got ta=%b tna=%b exp ta=0100 tna=0000", take_action, take_no_action);
    end
    total++;
    if (jdo !== d || jir !== 2'd2 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL single_data got jdo=%h jir=%0d valid=%b exp jdo=%h jir=2 valid=0", jdo, jir, cmd_valid, d);
    end
    step(1);
    total++;
    if (take_action !== 4'b0000 || jdo !== d) begin
      bad++; $display("FAIL single_hold got ta=%b jdo=%h exp ta=0000 jdo=%h", take_action, jdo, d);
    end
  endtask

  task automatic test_overflow;
    logic [SR_W-1:0] v [5];
    do_reset;
    for (int i = 0; i < 5; i++) begin
      v[i] = mk(i[0], 36'h00A0000 + 36'(i));
      push_udr(i[1:0], v[i]);
    end
    total++;
    if (level !== 3'd4 || overflow !== 1'b1 || cmd_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_state got level=%0d ovf=%b valid=%b exp 4/1/1", level, overflow, cmd_valid);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (jdo !== v[i] || jir !== i[1:0]) begin
        bad++; $display("FAIL ovf_pop%0d got jdo=%h jir=%0d exp jdo=%h jir=%0d", i, jdo, jir, v[i], i);
      end
      total++;
      if (take_action !== (i[0] ? (4'b1 << i) : 4'b0) || take_no_action !== (i[0] ? 4'b0 : (4'b1 << i))) begin
        bad++; $display("FAIL ovf_strobe%0d got ta=%b tna=%b", i, take_action, take_no_action);
      end
    end
    cmd_ready = 1'b0;
    step(1);
    total++;
    if (level !== 3'd0 || overflow !== 1'b1 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_drain got level=%0d ovf=%b valid=%b exp 0/1/0", level, overflow, cmd_valid);
    end
  endtask

  task automatic test_full_push_pop;
    logic [SR_W-1:0] v [5];
    do_reset;
    for (int i = 0; i < 5; i++) v[i] = mk(1'b1, 36'h0B00000 + 36'(i));
    for (int i = 0; i < 4; i++) push_udr(i[1:0], v[i]);
    total++;
    if (level !== 3'd4) begin bad++; $display("FAIL full_fill got level=%0d exp 4", level); end
    ir_in = 2'd1; sr = v[4]; udr_toggle = ~udr_toggle;
    step(2);
    cmd_ready = 1'b1;
    step(1);
    total++;
    if (jdo !== v[0] || level !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL full_pushpop got jdo=%h level=%0d ovf=%b exp jdo=%h level=4 ovf=0", jdo, level, overflow, v[0]);
    end
    for (int i = 1; i < 5; i++) begin
      step(1);
      total++;
      if (jdo !== v[i]) begin bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, jdo, v[i]); end
    end
    cmd_ready = 1'b0;
    total++;
    if (jir !== 2'd1 || level !== 3'd0) begin
      bad++; $display("FAIL full_last got jir=%0d level=%0d exp jir=1 level=0", jir, level);
    end
  endtask

  task automatic test_flush;
    logic [SR_W-1:0] x;
    do_reset;
    for (int i = 0; i < 5; i++) push_udr(2'd0, mk(1'b1, 36'(i + 1)));
    uir_toggle = ~uir_toggle;
    step(2);
    total++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL flush_early got level=%0d ovf=%b exp 4/1", level, overflow);
    end
    step(1);
    total++;
    if (level !== 3'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL flush got level=%0d valid=%b ovf=%b exp 0/0/0", level, cmd_valid, overflow);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      total++;
      if (take_action !== 4'b0 || take_no_action !== 4'b0) begin
        bad++; $display("FAIL flush_nostrobe got ta=%b tna=%b exp 0/0", take_action, take_no_action);
      end
    end
    cmd_ready = 1'b0;
    x = mk(1'b1, 36'hCAFE);
    ir_in = 2'd2; sr = x;
    udr_toggle = ~udr_toggle; uir_toggle = ~uir_toggle;
    step(3);
    total++;
    if (level !== 3'd1 || overflow !== 1'b0) begin
      bad++; $display("FAIL flush_push got level=%0d ovf=%b exp 1/0", level, overflow);
    end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    total++;
    if (jdo !== x || take_action !== 4'b0100) begin
      bad++; $display("FAIL flush_push_pop got jdo=%h ta=%b exp jdo=%h ta=0100", jdo, take_action, x);
    end
  endtask

  task automatic test_no_action;
    do_reset;
    push_udr(2'd3, mk(1'b0, 36'h5A5A5));
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    total++;
    if (take_no_action !== 4'b1000 || take_action !== 4'b0000 || jir !== 2'd3) begin
      bad++; $display("FAIL no_action got tna=%b ta=%b jir=%0d exp 1000/0000/3", take_no_action, take_action, jir);
    end
    step(1);
    total++;
    if (take_no_action !== 4'b0000) begin bad++; $display("FAIL no_action_clear got=%b exp=0000", take_no_action); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_ta  [4] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000};
    logic [3:0] exp_tna [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    do_reset;
    push_udr(2'd0, mk(1'b1, 36'h11));
    push_udr(2'd1, mk(1'b0, 36'h22));
    push_udr(2'd2, mk(1'b1, 36'h33));
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (take_action !== exp_ta[i] || take_no_action !== exp_tna[i]) begin
        bad++; $display("FAIL b2b%0d got ta=%b tna=%b exp ta=%b tna=%b", i, take_action, take_no_action, exp_ta[i], exp_tna[i]);
      end
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset;
    push_udr(2'd3, mk(1'b1, 36'h77));
    push_udr(2'd1, mk(1'b0, 36'h88));
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    total++;
    if (take_action !== 4'b1000 || level !== 3'd1) begin
      bad++; $display("FAIL arst_pre got ta=%b level=%0d exp 1000/1", take_action, level);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({cmd_valid, level, overflow, jdo, jir, take_action, take_no_action} !== '0) begin
      bad++; $display("FAIL arst got valid=%b level=%0d ovf=%b jdo=%h jir=%0d ta=%b tna=%b exp all 0",
                      cmd_valid, level, overflow, jdo, jir, take_action, take_no_action);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_full_push_pop;
    test_flush;
    test_no_action;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
